sticky_flag_bank: RTL and testbench
===================================

Name: sticky_flag_bank

Overview:
- Parametrised multi-channel successor to the single set/reset latch.
- CH independent sticky flags, each selectable per channel as level- or rising-edge-triggered.
- Per-channel write-1-to-clear; configurable set/clear priority.
- Saturating per-channel event counters, read and cleared through a clear-on-read port.
- Masked aggregate interrupt for the status/interrupt block.

Parameters:
- CH, 8, number of channels (1..32).
- CNT_W, 4, event counter width per channel (2..16).
- SET_WINS, 1, 1 = set beats clear on the same cycle; 0 = clear beats set.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- set_in  in  CH  per-channel set request.
- edge_mode  in  CH  1 = trigger on rising edge of set_in[i]; 0 = trigger while set_in[i] high.
- clr  in  CH  write-1-to-clear per flag, one-cycle pulse expected.
- mask  in  CH  1 = channel excluded from irq.
- rd_en  in  1  counter read strobe.
- rd_sel  in  max(1,$clog2(CH))  channel index for read.
- flags  out  CH  sticky flag state.
- cnt_out  out  CNT_W  counter value captured by the last read.
- cnt_ovf  out  1  1 = captured counter had saturated.
- irq  out  1  aggregate masked interrupt.

Behaviour:
- Reset, checked on posedge only while reset_n=0:
  - flags=0, all counters=0, prev_set=0.
  - cnt_out=0, cnt_ovf=0, irq=0.
- prev_set[i] registers set_in[i] every cycle. Because it resets to 0, a set_in held high through reset release yields an edge-mode trigger on the first active cycle.
- Trigger: trig[i] = edge_mode[i] ? (set_in[i] & ~prev_set[i]) : set_in[i].
- Flag update, visible on flags the cycle after the trigger/clear edge:
  - trig & clr: flag = SET_WINS.
  - trig only: flag = 1.
  - clr only: flag = 0.
  - neither: hold.
- Changing edge_mode mid-operation takes effect the same cycle. prev_set is unaffected.
- Counters:
  - cnt[i] increments by 1 on each cycle trig[i]=1, independent of flag state and clr.
  - cnt[i] saturates at 2^CNT_W-1 with no wrap.
- Clear-on-read, when rd_en=1 and rd_sel<CH:
  - Next cycle, cnt_out = cnt[rd_sel] value before this cycle's update.
  - cnt_ovf = (that value == 2^CNT_W-1).
  - cnt[rd_sel] becomes 1 if trig[rd_sel] in the same cycle, else 0. The same-cycle event is never lost.
- rd_en with rd_sel>=CH: cnt_out=0, cnt_ovf=0 next cycle, no counter modified.
- rd_en=0: cnt_out and cnt_ovf hold.
- irq <= |(flags & ~mask), registered from the flag register. Latency is therefore 2 cycles from trigger edge to irq, and 2 cycles from clr to irq deassert (if no other unmasked flag is set).
- Mask changes affect irq one cycle later. Mask never alters flags or counters.
- Reset asserted mid-operation overrides all inputs that cycle, including rd_en, set_in and clr.

Optional Feature:
- Macro: STICKY_FLAG_BANK_IRQ_PULSE_EN.
- Defined:
  - irq is a single-cycle pulse, asserted on the cycle the aggregate term |(flags & ~mask) goes 0->1, computed against the previous aggregate registered value.
  - The aggregate history register resets to 0.
  - A new set while the aggregate is already 1 produces no further pulse.
- Undefined: irq is the level described in Behaviour.

Test Plan:
- Reset/level set: reset_n=0 for 2 cycles with set_in=8'hFF, edge_mode=0 -> all outputs 0. Release, then set_in[3]=1 for 1 cycle -> flags=8'h08 next cycle, irq=1 one cycle later, mask=0.
- Edge mode: edge_mode[0]=1, set_in[0] held high 5 cycles, then rd_en/rd_sel=0 -> cnt_out=1, cnt_ovf=0. With edge_mode[0]=0 and the same stimulus -> cnt_out=5.
- Priority: trig[2] and clr[2] on the same cycle -> flags[2]=1 with SET_WINS=1, flags[2]=0 with SET_WINS=0.
- Saturation and read collision:
  - CNT_W=4, 20 level triggers on channel 1, then rd_en with rd_sel=1 -> cnt_out=15, cnt_ovf=1.
  - Read concurrent with a trigger -> next read returns 1.
- Mask/clear: flags 0 and 5 set, mask=8'h01 -> irq=1. clr=8'h20 -> irq=0 two cycles later, flags=8'h01.
- Pulse mode (macro defined): set ch0, then ch4 3 cycles later -> exactly one irq pulse. Clear both, set ch4 -> second one-cycle pulse.

Source files
------------

// File: rtl/sticky_flag_bank_if.sv
// ---------------------------------------------------------------------------
// sticky_flag_bank_if
//   Signal bundle between the sticky flag bank and its controller.
//   Parameters:
//     CH     number of channels
//     CNT_W  event counter width
//   Signals:
//     set_in     per-channel set request
//     edge_mode  1 = rising-edge trigger, 0 = level trigger
//     clr        write-1-to-clear per flag
//     mask       1 = channel excluded from irq
//     rd_en      counter read strobe (clear-on-read)
//     rd_sel     channel index for the read
//     flags      sticky flag state
//     cnt_out    counter value captured by the last read
//     cnt_ovf    captured counter had saturated
//     irq        aggregate masked interrupt
//   Modports: master drives the requests, slave is the flag bank.
// ---------------------------------------------------------------------------
interface sticky_flag_bank_if #(
  parameter int CH    = 8,
  parameter int CNT_W = 4
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]    set_in;
  logic [CH-1:0]    edge_mode;
  logic [CH-1:0]    clr;
  logic [CH-1:0]    mask;
  logic             rd_en;
  logic [SEL_W-1:0] rd_sel;
  logic [CH-1:0]    flags;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_ovf;
  logic             irq;

  modport master (
    output set_in, edge_mode, clr, mask, rd_en, rd_sel,
    input  flags, cnt_out, cnt_ovf, irq
  );

  modport slave (
    input  set_in, edge_mode, clr, mask, rd_en, rd_sel,
    output flags, cnt_out, cnt_ovf, irq
  );
endinterface

// File: rtl/sticky_flag_bank.sv
// ---------------------------------------------------------------------------
// sticky_flag_bank
//   CH independent sticky flags with per-channel level/edge triggering,
//   write-1-to-clear, saturating per-channel event counters read through a
//   clear-on-read port, and a masked aggregate interrupt.
//   Parameters:
//     CH        number of channels (1..32)
//     CNT_W     event counter width (2..16)
//     SET_WINS  1 = set beats clear on the same cycle, 0 = clear beats set
//   Ports:
//     clk       system clock, everything on posedge
//     reset_n   synchronous active-low reset
//     bus       sticky_flag_bank_if.slave (requests in, status out)
//   Optional feature:
//     STICKY_FLAG_BANK_IRQ_PULSE_EN  when defined, irq is a one-cycle pulse
//     on each 0->1 transition of the masked aggregate instead of a level.
// ---------------------------------------------------------------------------
module sticky_flag_bank #(
  parameter int CH       = 8,
  parameter int CNT_W    = 4,
  parameter bit SET_WINS = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  sticky_flag_bank_if.slave bus
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0]    prev_set;
  logic [CH-1:0]    trig;
  logic [CH-1:0]    flags_q;
  logic [CH-1:0]    flags_d;
  logic [CNT_W-1:0] cnt_q [CH];
  logic [CNT_W-1:0] rd_val;
  logic             rd_hit;
  logic             agg;
  logic [CNT_W-1:0] cnt_out_q;
  logic             cnt_ovf_q;
  logic             irq_q;

  // Edge mode compares against last cycle's set_in; level mode uses it raw.
  assign trig = (bus.edge_mode & bus.set_in & ~prev_set)
              | (~bus.edge_mode & bus.set_in);

  generate
    if (SET_WINS) begin : g_set_wins
      assign flags_d = (flags_q & ~bus.clr) | trig;
    end else begin : g_clr_wins
      assign flags_d = (flags_q | trig) & ~bus.clr;
    end
  endgenerate

  // Out-of-range selects read a zero instead of a nonexistent entry.
  assign rd_hit = bus.rd_en && (int'(bus.rd_sel) < CH);

  always_comb begin
    // NOTE: default first so every path assigns rd_val and no latch is inferred.
    rd_val = '0;
    for (int i = 0; i < CH; i++) begin
      if (bus.rd_sel == SEL_W'(i)) rd_val = cnt_q[i];
    end
  end

  assign agg = |(flags_q & ~bus.mask);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      prev_set  <= '0;
      flags_q   <= '0;
      cnt_out_q <= '0;
      cnt_ovf_q <= 1'b0;
      // NOTE: the counter array is small and must read zero after reset, so it
      // is cleared here rather than left to power-up state.
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      prev_set <= bus.set_in;
      flags_q  <= flags_d;

      if (bus.rd_en) begin
        cnt_out_q <= rd_hit ? rd_val : '0;
        cnt_ovf_q <= rd_hit && (rd_val == CNT_MAX);
      end

      for (int i = 0; i < CH; i++) begin
        if (rd_hit && (bus.rd_sel == SEL_W'(i))) begin
          // A trigger coinciding with the read restarts the count at 1.
          cnt_q[i] <= trig[i] ? CNT_W'(1) : '0;
        end else if (trig[i] && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef STICKY_FLAG_BANK_IRQ_PULSE_EN
  logic agg_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      agg_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      agg_q <= agg;
      irq_q <= agg & ~agg_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= agg;
  end
`endif

  assign bus.flags   = flags_q;
  assign bus.cnt_out = cnt_out_q;
  assign bus.cnt_ovf = cnt_ovf_q;
  assign bus.irq     = irq_q;
endmodule

// File: tb/tb_sticky_flag_bank.sv
// ---------------------------------------------------------------------------
// tb_sticky_flag_bank
//   Directed bench for sticky_flag_bank (CH=8, CNT_W=4). Two instances share
//   all inputs: dut_a uses SET_WINS=1, dut_b uses SET_WINS=0. Inputs change
//   1 time unit after posedge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sticky_flag_bank;
  localparam int CH    = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset_n;

  logic [CH-1:0] set_in, edge_mode, clr, mask;
  logic          rd_en;
  logic [2:0]    rd_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sticky_flag_bank_if #(.CH(CH), .CNT_W(CNT_W)) bus_a ();
  sticky_flag_bank_if #(.CH(CH), .CNT_W(CNT_W)) bus_b ();

  assign bus_a.set_in    = set_in;
  assign bus_a.edge_mode = edge_mode;
  assign bus_a.clr       = clr;
  assign bus_a.mask      = mask;
  assign bus_a.rd_en     = rd_en;
  assign bus_a.rd_sel    = rd_sel;
  assign bus_b.set_in    = set_in;
  assign bus_b.edge_mode = edge_mode;
  assign bus_b.clr       = clr;
  assign bus_b.mask      = mask;
  assign bus_b.rd_en     = rd_en;
  assign bus_b.rd_sel    = rd_sel;

  sticky_flag_bank #(.CH(CH), .CNT_W(CNT_W), .SET_WINS(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  sticky_flag_bank #(.CH(CH), .CNT_W(CNT_W), .SET_WINS(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_all();
    clr = '1;
    tick();
    clr = '0;
    tick(3);
  endtask

`ifdef STICKY_FLAG_BANK_IRQ_PULSE_EN
  int pulses;
  int high_run;
  int max_run;
`endif

  initial begin
    reset_n = 1'b0; set_in = '1; edge_mode = '0; clr = '0; mask = '0;
    rd_en = 1'b0; rd_sel = '0;
    #1;

    // Reset with all level triggers held high.
    tick(2);
    check("rst_flags",   32'(bus_a.flags),   32'h00);
    check("rst_cnt_out", 32'(bus_a.cnt_out), 32'h0);
    check("rst_cnt_ovf", 32'(bus_a.cnt_ovf), 32'h0);
    check("rst_irq",     32'(bus_a.irq),     32'h0);

    // Release, then one-cycle level set on channel 3.
    set_in = '0; reset_n = 1'b1;
    tick();
    check("idle_flags", 32'(bus_a.flags), 32'h00);
    set_in = 8'h08;
    tick();
    set_in = '0;
    check("lvl_flags", 32'(bus_a.flags), 32'h08);
`ifndef STICKY_FLAG_BANK_IRQ_PULSE_EN
    check("lvl_irq_lat1", 32'(bus_a.irq), 32'h0);
`endif
    tick();
`ifndef STICKY_FLAG_BANK_IRQ_PULSE_EN
    check("lvl_irq_lat2", 32'(bus_a.irq), 32'h1);
`else
    check("pulse_first", 32'(bus_a.irq), 32'h1);
`endif
    clr = 8'h08;
    tick();
    clr = '0;
    check("w1c_flags", 32'(bus_a.flags), 32'h00);
    tick();
    check("w1c_irq", 32'(bus_a.irq), 32'h0);

    // Edge mode: 5 cycles high counts once.
    edge_mode = 8'h01; set_in = 8'h01;
    tick(5);
    set_in = '0; rd_en = 1'b1; rd_sel = 3'd0;
    tick();
    rd_en = 1'b0;
    check("edge_cnt", 32'(bus_a.cnt_out), 32'h1);
    check("edge_ovf", 32'(bus_a.cnt_ovf), 32'h0);

    // Level mode: same stimulus counts every cycle.
    edge_mode = '0; set_in = 8'h01;
    tick(5);
    set_in = '0; rd_en = 1'b1; rd_sel = 3'd0;
    tick();
    rd_en = 1'b0;
    check("level_cnt", 32'(bus_a.cnt_out), 32'h5);

    // Set/clear priority on channel 2.
    clear_all();
    set_in = 8'h04; clr = 8'h04;
    tick();
    set_in = '0; clr = '0;
    check("prio_set_wins", 32'(bus_a.flags[2]), 32'h1);
    check("prio_clr_wins", 32'(bus_b.flags[2]), 32'h0);
    set_in = 8'h04;
    tick();
    set_in = '0;
    check("prio_b_set_only", 32'(bus_b.flags[2]), 32'h1);

    // Saturation on channel 1.
    set_in = 8'h02;
    tick(20);
    set_in = '0; rd_en = 1'b1; rd_sel = 3'd1;
    tick();
    rd_en = 1'b0;
    check("sat_cnt", 32'(bus_a.cnt_out), 32'hF);
    check("sat_ovf", 32'(bus_a.cnt_ovf), 32'h1);

    // Read colliding with a trigger keeps the event.
    set_in = 8'h02; rd_en = 1'b1; rd_sel = 3'd1;
    tick();
    set_in = '0;
    check("coll_cnt0", 32'(bus_a.cnt_out), 32'h0);
    check("coll_ovf0", 32'(bus_a.cnt_ovf), 32'h0);
    tick();
    rd_en = 1'b0;
    check("coll_cnt1", 32'(bus_a.cnt_out), 32'h1);
    tick();
    check("rd_hold", 32'(bus_a.cnt_out), 32'h1);

    // Mask and clear.
    clear_all();
    set_in = 8'h21;
    tick();
    set_in = '0; mask = 8'h01;
    tick();
`ifndef STICKY_FLAG_BANK_IRQ_PULSE_EN
    check("mask_irq", 32'(bus_a.irq), 32'h1);
`endif
    clr = 8'h20;
    tick();
    clr = '0;
    check("mask_clr_flags", 32'(bus_a.flags), 32'h01);
`ifndef STICKY_FLAG_BANK_IRQ_PULSE_EN
    check("mask_clr_irq1", 32'(bus_a.irq), 32'h1);
`endif
    tick();
    check("mask_clr_irq2", 32'(bus_a.irq), 32'h0);
    mask = '0;
    tick();
`ifndef STICKY_FLAG_BANK_IRQ_PULSE_EN
    check("unmask_irq", 32'(bus_a.irq), 32'h1);
`else
    check("unmask_pulse", 32'(bus_a.irq), 32'h1);
`endif

`ifdef STICKY_FLAG_BANK_IRQ_PULSE_EN
    // Two sets three cycles apart give one pulse.
    clear_all();
    pulses = 0; high_run = 0; max_run = 0;
    for (int k = 0; k < 10; k++) begin
      set_in = (k == 0) ? 8'h01 : ((k == 3) ? 8'h10 : 8'h00);
      tick();
      if (bus_a.irq) begin
        if (high_run == 0) pulses++;
        high_run++;
        if (high_run > max_run) max_run = high_run;
      end else begin
        high_run = 0;
      end
    end
    set_in = '0;
    check("pulse_count1", 32'(pulses), 32'd1);
    check("pulse_width1", 32'(max_run), 32'd1);

    // Clear both, set ch4 again: a second pulse.
    clear_all();
    pulses = 0; high_run = 0; max_run = 0;
    for (int k = 0; k < 6; k++) begin
      set_in = (k == 0) ? 8'h10 : 8'h00;
      tick();
      if (bus_a.irq) begin
        if (high_run == 0) pulses++;
        high_run++;
        if (high_run > max_run) max_run = high_run;
      end else begin
        high_run = 0;
      end
    end
    set_in = '0;
    check("pulse_count2", 32'(pulses), 32'd1);
    check("pulse_width2", 32'(max_run), 32'd1);
`endif

    // Mid-operation reset overrides set, clear and read.
    set_in = 8'hFF; rd_en = 1'b1; rd_sel = 3'd0; reset_n = 1'b0;
    tick();
    check("rst2_flags",   32'(bus_a.flags),   32'h00);
    check("rst2_cnt_out", 32'(bus_a.cnt_out), 32'h0);
    check("rst2_irq",     32'(bus_a.irq),     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
